jtcop_obj_linebuf: RTL and testbench

- Double-buffered object line buffer placed directly downstream of the object draw stage.
- The draw stage writes decoded 8-bit object pixels for line N+1 into one bank while the other bank is read out at hdump for line N.
- Banks swap on every HS rising edge. Each read location is erased after being read, so the bank is clean when it becomes the write bank again.
- The output feeds the colour mixer.

---
 rtl/jtcop_obj_linebuf.sv | 113 +++++++++++
 tb/tb_jtcop_obj_linebuf.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtcop_obj_linebuf.sv
// Double-buffered object line buffer: the draw stage fills one bank while the other is
// read out at hdump and erased behind the beam. Banks swap on every HS rising edge.
module jtcop_obj_linebuf #(
  parameter logic [7:0] ALPHA      = 8'h0f,
  parameter bit         PRIO_FIRST = 1'b1
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       pxl_cen,
  input  logic       HS,
  input  logic [8:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       wr_we,
  input  logic [8:0] hdump,
  output logic       busy,
  output logic [7:0] pxl
);
  localparam int unsigned AW    = 9;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 2 ** (AW + 1);

  // sel is the bank MSB: write bank = sel, read bank = ~sel
  logic [DW-1:0] mem [DEPTH];

  logic          sel, hs_l, hs_rise;
  logic [AW-1:0] cnt;

  logic          s0_we, s0_bank;
  logic [AW-1:0] s0_addr;
  logic [DW-1:0] s0_data, s0_rd;

  logic          s1_we, s1_bank;
  logic [AW-1:0] s1_addr;
  logic [DW-1:0] s1_data;

  logic [DW-1:0] rd_q;
  logic          er_pend, er_bank;
  logic [AW-1:0] er_addr;

  logic [DW-1:0] stored;
  logic          commit, er_hit;

  function automatic logic transp(input logic [DW-1:0] v);
    return v[3:0] == ALPHA[3:0];
  endfunction

  // The stage-0 read misses a commit landing on the same edge, so forward it from stage 1
  always_comb begin
    hs_rise = HS & ~hs_l;
    stored  = s0_rd;
    if (s1_we && s1_bank == s0_bank && s1_addr == s0_addr) stored = s1_data;
    commit  = s0_we && !transp(s0_data) && (!PRIO_FIRST || transp(stored));
    er_hit  = er_pend && er_bank == ~sel && er_addr == hdump;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel     <= 1'b0;
      hs_l    <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b1;
      s0_we   <= 1'b0;
      s0_bank <= 1'b0;
      s0_addr <= '0;
      s0_data <= '0;
      s0_rd   <= '0;
      s1_we   <= 1'b0;
      s1_bank <= 1'b0;
      s1_addr <= '0;
      s1_data <= '0;
      rd_q    <= ALPHA;
      pxl     <= ALPHA;
      er_pend <= 1'b0;
      er_bank <= 1'b0;
      er_addr <= '0;
    end else begin
      hs_l <= HS;
      if (hs_rise) sel <= ~sel;
      if (busy) begin
        cnt <= cnt + AW'(1);
        if (&cnt) busy <= 1'b0;
      end
      s0_we   <= wr_we & ~busy;
      s0_bank <= sel;
      s0_addr <= wr_addr;
      s0_data <= wr_data;
      s0_rd   <= mem[{sel, wr_addr}];
      s1_we   <= commit;
      s1_bank <= s0_bank;
      s1_addr <= s0_addr;
      s1_data <= s0_data;
      er_pend <= pxl_cen & ~busy;
      // Read the pre-swap read bank; the erase of the same slot lands on the next clk
      if (pxl_cen && !busy) begin
        pxl     <= rd_q;
        rd_q    <= er_hit ? ALPHA : mem[{~sel, hdump}];
        er_bank <= ~sel;
        er_addr <= hdump;
      end
    end
  end

  // Write ports: sweep clears both banks; otherwise erase on the read bank, commit on the issue bank
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[{1'b0, cnt}] <= ALPHA;
      mem[{1'b1, cnt}] <= ALPHA;
    end else begin
      if (er_pend) mem[{er_bank, er_addr}] <= ALPHA;
      if (commit)  mem[{s0_bank, s0_addr}] <= s0_data;
    end
  end
endmodule

// File: tb/tb_jtcop_obj_linebuf.sv
// Directed bench for jtcop_obj_linebuf; two instances cover both PRIO_FIRST settings.
module tb_jtcop_obj_linebuf;
  logic       rst, clk, pxl_cen, HS, wr_we;
  logic [8:0] wr_addr, hdump;
  logic [7:0] wr_data;
  logic       busy1, busy0;
  logic [7:0] pxl1, pxl0;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_mem [512];

  jtcop_obj_linebuf #(.ALPHA(8'h0f), .PRIO_FIRST(1'b1)) dut1 (
    .rst(rst), .clk(clk), .pxl_cen(pxl_cen), .HS(HS), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_we(wr_we), .hdump(hdump), .busy(busy1), .pxl(pxl1));

  jtcop_obj_linebuf #(.ALPHA(8'h0f), .PRIO_FIRST(1'b0)) dut0 (
    .rst(rst), .clk(clk), .pxl_cen(pxl_cen), .HS(HS), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_we(wr_we), .hdump(hdump), .busy(busy0), .pxl(pxl0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [8:0] a, input logic [7:0] d);
    wr_addr = a; wr_data = d; wr_we = 1'b1;
    tick();
    wr_we = 1'b0;
  endtask

  task automatic drain();
    repeat (3) tick();
  endtask

  task automatic swap();
    HS = 1'b1;
    tick();
    HS = 1'b0;
    tick();
  endtask

  task automatic pix(input logic [8:0] h);
    hdump = h; pxl_cen = 1'b1;
    tick();
    pxl_cen = 1'b0;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 512; i++) exp_mem[i] = 8'h0f;
  endtask

  // Reads the whole current read bank; pxl lags hdump by one pixel
  task automatic check_bank(input string name);
    int bad1, bad0, f1, f0;
    logic [7:0] a1, a0;
    bad1 = 0; bad0 = 0; f1 = -1; f0 = -1; a1 = '0; a0 = '0;
    pix(9'd0);
    for (int i = 1; i <= 512; i++) begin
      pix(9'(i));
      if (pxl1 !== exp_mem[i-1]) begin
        if (f1 < 0) begin f1 = i - 1; a1 = pxl1; end
        bad1++;
      end
      if (pxl0 !== exp_mem[i-1]) begin
        if (f0 < 0) begin f0 = i - 1; a0 = pxl0; end
        bad0++;
      end
    end
    checks += 2;
    if (bad1 != 0) begin
      errors++;
      $display("FAIL %s prio1: %0d bad, first addr %0d got %h want %h", name, bad1, f1, a1, exp_mem[f1]);
    end
    if (bad0 != 0) begin
      errors++;
      $display("FAIL %s prio0: %0d bad, first addr %0d got %h want %h", name, bad0, f0, a0, exp_mem[f0]);
    end
  endtask

  task automatic clean();
    for (int i = 0; i < 512; i++) pix(9'(i));
    swap();
    for (int i = 0; i < 512; i++) pix(9'(i));
    swap();
  endtask

  task automatic test_reset();
    int n, badp;
    rst = 1'b1;
    repeat (2) tick();
    checks += 2;
    if (busy1 !== 1'b1 || busy0 !== 1'b1) begin
      errors++; $display("FAIL reset_busy: got %b/%b want 1", busy1, busy0);
    end
    if (pxl1 !== 8'h0f || pxl0 !== 8'h0f) begin
      errors++; $display("FAIL reset_pxl: got %h/%h want 0f", pxl1, pxl0);
    end
    rst = 1'b0; pxl_cen = 1'b1; hdump = 9'd3;
    n = 0; badp = 0;
    while (busy1 && n < 600) begin
      tick();
      n++;
      if (pxl1 !== 8'h0f || pxl0 !== 8'h0f) badp++;
    end
    pxl_cen = 1'b0;
    checks += 3;
    if (n != 512) begin
      errors++; $display("FAIL sweep_len: got %0d clk want 512", n);
    end
    if (busy0 !== 1'b0) begin
      errors++; $display("FAIL sweep_len_prio0: busy got %b want 0", busy0);
    end
    if (badp != 0) begin
      errors++; $display("FAIL sweep_pxl: %0d non-0f samples want 0", badp);
    end
  endtask

  task automatic test_sweep();
    clear_exp();
    check_bank("sweep_bank_a");
    swap();
    check_bank("sweep_bank_b");
  endtask

  task automatic test_basic();
    wr(9'd10, 8'h35); wr(9'd0, 8'h41); wr(9'd511, 8'h52);
    drain();
    swap();
    pix(9'd9);
    pix(9'd10);
    checks++;
    if (pxl1 !== 8'h0f) begin errors++; $display("FAIL basic_9: got %h want 0f", pxl1); end
    pix(9'd10);
    checks++;
    if (pxl1 !== 8'h35) begin errors++; $display("FAIL basic_10: got %h want 35", pxl1); end
    pix(9'd10);
    checks++;
    if (pxl1 !== 8'h0f) begin errors++; $display("FAIL basic_hold: got %h want 0f", pxl1); end
    pix(9'd11);
    checks++;
    if (pxl1 !== 8'h0f) begin errors++; $display("FAIL basic_11: got %h want 0f", pxl1); end
    pix(9'd511);
    pix(9'd0);
    checks++;
    if (pxl1 !== 8'h52 || pxl0 !== 8'h52) begin
      errors++; $display("FAIL basic_511: got %h/%h want 52", pxl1, pxl0);
    end
    pix(9'd1);
    checks++;
    if (pxl1 !== 8'h41 || pxl0 !== 8'h41) begin
      errors++; $display("FAIL basic_0: got %h/%h want 41", pxl1, pxl0);
    end
    swap(); swap();
    pix(9'd10);
    pix(9'd11);
    checks++;
    if (pxl1 !== 8'h0f) begin errors++; $display("FAIL basic_erased: got %h want 0f", pxl1); end
  endtask

  task automatic test_prio();
    wr(9'd100, 8'h21); wr(9'd100, 8'h47);
    drain();
    wr(9'd150, 8'h2a); drain(); wr(9'd150, 8'h4b); drain();
    wr(9'd200, 8'h33); drain(); wr(9'd200, 8'h5f); drain();
    wr(9'd210, 8'h33); wr(9'd210, 8'h5f); drain();
    swap();
    pix(9'd100); pix(9'd101);
    checks += 2;
    if (pxl1 !== 8'h21) begin errors++; $display("FAIL prio_b2b_first: got %h want 21", pxl1); end
    if (pxl0 !== 8'h47) begin errors++; $display("FAIL prio_b2b_last: got %h want 47", pxl0); end
    pix(9'd150); pix(9'd151);
    checks += 2;
    if (pxl1 !== 8'h2a) begin errors++; $display("FAIL prio_first: got %h want 2a", pxl1); end
    if (pxl0 !== 8'h4b) begin errors++; $display("FAIL prio_last: got %h want 4b", pxl0); end
    pix(9'd200); pix(9'd201);
    checks++;
    if (pxl1 !== 8'h33 || pxl0 !== 8'h33) begin
      errors++; $display("FAIL transp_skip: got %h/%h want 33", pxl1, pxl0);
    end
    pix(9'd210); pix(9'd211);
    checks++;
    if (pxl1 !== 8'h33 || pxl0 !== 8'h33) begin
      errors++; $display("FAIL transp_b2b: got %h/%h want 33", pxl1, pxl0);
    end
  endtask

  task automatic test_swap_cen();
    wr(9'd40, 8'h99);
    drain();
    swap();
    HS = 1'b1; pxl_cen = 1'b1; hdump = 9'd40;
    tick();
    HS = 1'b0; pxl_cen = 1'b0;
    tick();
    pix(9'd41);
    checks++;
    if (pxl1 !== 8'h99 || pxl0 !== 8'h99) begin
      errors++; $display("FAIL swap_cen_read: got %h/%h want 99", pxl1, pxl0);
    end
    swap();
    pix(9'd40); pix(9'd41);
    checks++;
    if (pxl1 !== 8'h0f || pxl0 !== 8'h0f) begin
      errors++; $display("FAIL swap_cen_erase: got %h/%h want 0f", pxl1, pxl0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    clean();
    for (int i = 0; i < 512; i++) begin
      d = 8'(i) | 8'h10;
      wr_addr = 9'(i); wr_data = d; wr_we = 1'b1; HS = (i == 256);
      tick();
    end
    wr_we = 1'b0; HS = 1'b0;
    drain();
    for (int i = 0; i < 512; i++) begin
      d = 8'(i) | 8'h10;
      exp_mem[i] = (i <= 256 && d[3:0] != 4'hf) ? d : 8'h0f;
    end
    check_bank("burst_old_bank");
    swap();
    for (int i = 0; i < 512; i++) begin
      d = 8'(i) | 8'h10;
      exp_mem[i] = (i > 256 && d[3:0] != 4'hf) ? d : 8'h0f;
    end
    check_bank("burst_new_bank");
  endtask

  task automatic test_reset_mid();
    int n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr_addr = 9'd5; wr_data = 8'h33; wr_we = 1'b1;
    repeat (200) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (busy1 !== 1'b1) begin errors++; $display("FAIL mid_rst_busy: got %b want 1", busy1); end
    rst = 1'b0;
    n = 0;
    while (busy1 && n < 600) begin
      tick();
      n++;
    end
    wr_we = 1'b0;
    checks++;
    if (n != 512) begin errors++; $display("FAIL mid_rst_len: got %0d clk want 512", n); end
    clear_exp();
    check_bank("mid_rst_bank_a");
    swap();
    check_bank("mid_rst_bank_b");
  endtask

  initial begin
    rst = 1'b1; pxl_cen = 1'b0; HS = 1'b0; wr_we = 1'b0;
    wr_addr = '0; wr_data = '0; hdump = '0;
    test_reset();
    test_sweep();
    test_basic();
    test_prio();
    test_swap_cen();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
